longdiv_seq: RTL and testbench

LONGDIV_SEQ -- requirements
Module: longdiv_seq

---
 rtl/longdiv_pkg.sv | 29 ++
 rtl/longdiv_step.sv | 24 ++
 rtl/longdiv_seq.sv | 153 +++++++++++++++
 tb/tb_longdiv_seq.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/longdiv_pkg.sv
// longdiv_pkg: shared types for the sequential restoring divider.
// Build option: define LONGDIV_SIGNED_EN to add the FIX state and two's-complement support.
package longdiv_pkg;

   // Widest operand the step result can carry; the divider slices diff[N:0] out of it.
   localparam int unsigned STEP_MAXW = 64;

`ifdef LONGDIV_SIGNED_EN
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;
`else
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd3
   } state_t;
`endif

   // One shift/trial-subtract result: the N+1-bit difference and the borrow out of it.
   typedef struct packed {
      logic [STEP_MAXW:0] diff;
      logic               borrow;
   } step_t;

endpackage

// File: rtl/longdiv_step.sv
// longdiv_step: one combinational restoring-division step.
// Forms {rem, a_msb} (N+1 bits) and subtracts the divisor; borrow=1 means the trial failed.
module longdiv_step
   import longdiv_pkg::*;
#(
   parameter int N = 16
) (
   input  logic [N-1:0] rem_i,
   input  logic         a_msb_i,
   input  logic [N-1:0] div_i,
   output step_t        res_o
);

   logic [N+1:0] sub;

   // Trial subtraction one bit wider than the partial remainder so the borrow is explicit.
   always_comb begin
      sub             = {1'b0, rem_i, a_msb_i} - {2'b00, div_i};
      res_o           = '0;
      res_o.diff[N:0] = sub[N:0];
      res_o.borrow    = sub[N+1];
   end

endmodule

// File: rtl/longdiv_seq.sv
// longdiv_seq: sequential restoring divider, one quotient bit per cycle, valid/ready handshakes.
// Build option: LONGDIV_SIGNED_EN enables signed operation (is_signed) through an extra FIX cycle.
module longdiv_seq
   import longdiv_pkg::*;
#(
   parameter int N = 16
) (
   input  logic         Clock,
   input  logic         Resetn,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] dividend,
   input  logic [N-1:0] divisor,
   input  logic         is_signed,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] quotient,
   output logic [N-1:0] remainder,
   output logic         div_by_zero
);

   localparam int CW = $clog2(N);

   state_t         state_q, state_d;
   logic [N-1:0]   a_q, a_d;      // dividend shifting out, quotient shifting in
   logic [N-1:0]   b_q, b_d;      // divisor magnitude
   logic [N-1:0]   r_q, r_d;      // partial remainder
   logic [CW-1:0]  cnt_q, cnt_d;  // steps still to run after the current one
   logic           dbz_q, dbz_d;

   step_t          step_res;

   longdiv_step #(.N(N)) u_step (
      .rem_i   (r_q),
      .a_msb_i (a_q[N-1]),
      .div_i   (b_q),
      .res_o   (step_res)
   );

   // diff[N] is always 0 on a successful trial, and bits above N are padding.
   logic [STEP_MAXW-N:0] unused_diff_hi;
   assign unused_diff_hi = step_res.diff[STEP_MAXW:N];

`ifdef LONGDIV_SIGNED_EN
   logic negq_q, negq_d;  // quotient must be negated in FIX
   logic negr_q, negr_d;  // remainder must be negated in FIX (dividend was negative)
`else
   logic unused_is_signed;
   assign unused_is_signed = is_signed;
`endif

   // Next-state and datapath updates; every register holds unless its state touches it.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      r_d     = r_q;
      cnt_d   = cnt_q;
      dbz_d   = dbz_q;
`ifdef LONGDIV_SIGNED_EN
      negq_d  = negq_q;
      negr_d  = negr_q;
`endif
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               state_d = CALC;
               cnt_d   = CW'(N - 1);
               a_d     = dividend;
               b_d     = divisor;
               r_d     = '0;
               dbz_d   = (divisor == '0);
`ifdef LONGDIV_SIGNED_EN
               negq_d  = is_signed & (dividend[N-1] ^ divisor[N-1]);
               negr_d  = is_signed & dividend[N-1];
               if (is_signed) begin
                  a_d = dividend[N-1] ? -dividend : dividend;
                  b_d = divisor[N-1]  ? -divisor  : divisor;
               end
`endif
               // Divide-by-zero result is fixed at accept; CALC then just forwards to DONE.
               if (divisor == '0) begin
                  a_d = '1;
                  r_d = dividend;
               end
            end
         end
         CALC: begin
            if (dbz_q) begin
               state_d = DONE;
            end else begin
               a_d = {a_q[N-2:0], ~step_res.borrow};
               r_d = step_res.borrow ? {r_q[N-2:0], a_q[N-1]} : step_res.diff[N-1:0];
               if (cnt_q == '0) begin
`ifdef LONGDIV_SIGNED_EN
                  state_d = FIX;
`else
                  state_d = DONE;
`endif
               end else begin
                  cnt_d = cnt_q - CW'(1);
               end
            end
         end
`ifdef LONGDIV_SIGNED_EN
         FIX: begin
            // MIN/-1 falls out naturally: |MIN| / 1 = MIN as an unsigned pattern, no negation.
            if (negq_q) a_d = -a_q;
            if (negr_q) r_d = -r_q;
            state_d = DONE;
         end
`endif
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers with asynchronous active-low reset.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         r_q     <= '0;
         cnt_q   <= '0;
         dbz_q   <= 1'b0;
`ifdef LONGDIV_SIGNED_EN
         negq_q  <= 1'b0;
         negr_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         r_q     <= r_d;
         cnt_q   <= cnt_d;
         dbz_q   <= dbz_d;
`ifdef LONGDIV_SIGNED_EN
         negq_q  <= negq_d;
         negr_q  <= negr_d;
`endif
      end
   end

   assign in_ready    = (state_q == IDLE);
   assign out_valid   = (state_q == DONE);
   assign quotient    = a_q;
   assign remainder   = r_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_longdiv_seq.sv
// tb_longdiv_seq: table-driven, hand-sequenced and randomized checks of longdiv_seq at N=8.
// Honours LONGDIV_SIGNED_EN when defined for the build.
module tb_longdiv_seq;

   localparam int N = 8;
`ifdef LONGDIV_SIGNED_EN
   localparam int LAT = N + 1;
`else
   localparam int LAT = N;
`endif

   logic         Clock;
   logic         Resetn;
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] dividend;
   logic [N-1:0] divisor;
   logic         is_signed;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] quotient;
   logic [N-1:0] remainder;
   logic         div_by_zero;

   longdiv_seq #(.N(N)) dut (
      .Clock       (Clock),
      .Resetn      (Resetn),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .dividend    (dividend),
      .divisor     (divisor),
      .is_signed   (is_signed),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   int cyc = 0;
   always @(posedge Clock) cyc <= cyc + 1;

   int n_vec = 0;
   int n_err = 0;
   int acc_cyc = 0;
   int hs_cyc = 0;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       sg;
      int         hold;
      logic [7:0] q;
      logic [7:0] r;
      logic       z;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: plain arithmetic from the operation's definition.
   function automatic logic [16:0] ref_div(input logic [7:0] a, input logic [7:0] b, input logic sg);
      logic [7:0] q;
      logic [7:0] r;
      int sa;
      int sb;
      if (b == 8'd0) return {8'hFF, a, 1'b1};
`ifdef LONGDIV_SIGNED_EN
      if (sg) begin
         sa = int'($signed(a));
         sb = int'($signed(b));
         q  = 8'(sa / sb);
         r  = 8'(sa % sb);
         return {q, r, 1'b0};
      end
`endif
      q = a / b;
      r = a % b;
      return {q, r, 1'b0};
   endfunction

   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic sg, input int hold,
                         input logic [7:0] eq, input logic [7:0] er, input logic ez,
                         input bit keep, input string tag);
      int lat;
      int waitc;
      @(negedge Clock);
      waitc = 0;
      while (!in_ready && waitc < 50) begin
         @(negedge Clock);
         waitc++;
      end
      chk({tag, "_in_ready_pre"}, 32'(in_ready), 32'd1);
      dividend  = a;
      divisor   = b;
      is_signed = sg;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      @(posedge Clock);
      #1;
      acc_cyc = cyc;
      if (!keep) in_valid = 1'b0;
      lat = 0;
      do begin
         @(posedge Clock);
         #1;
         lat++;
         if (keep && !out_valid) begin
            dividend = 8'($urandom);
            divisor  = 8'($urandom);
         end
      end while (!out_valid && lat < 40);
      in_valid = 1'b0;
      chk({tag, "_latency"}, 32'(lat), ez ? 32'd1 : 32'(LAT));
      chk({tag, "_q"}, 32'(quotient), 32'(eq));
      chk({tag, "_r"}, 32'(remainder), 32'(er));
      chk({tag, "_dbz"}, 32'(div_by_zero), 32'(ez));
      for (int h = 0; h < hold; h++) begin
         @(posedge Clock);
         #1;
         chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
         chk({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
         chk({tag, "_hold_q"}, 32'(quotient), 32'(eq));
         chk({tag, "_hold_r"}, 32'(remainder), 32'(er));
         chk({tag, "_hold_dbz"}, 32'(div_by_zero), 32'(ez));
      end
      out_ready = 1'b1;
      @(posedge Clock);
      #1;
      hs_cyc    = cyc;
      out_ready = 1'b0;
      chk({tag, "_post_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_post_in_ready"}, 32'(in_ready), 32'd1);
      $display("%s: a=%02h b=%02h s=%0d hold=%0d -> q=%02h r=%02h dbz=%0d lat=%0d",
               tag, a, b, sg, hold, eq, er, ez, lat);
   endtask

   initial begin
      logic [16:0] exp;
      logic [7:0]  ra;
      logic [7:0]  rb;
      logic        rs;
      bit          seen;
      int          prev_hs;

      Resetn    = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      dividend  = '0;
      divisor   = '0;
      is_signed = 1'b0;

      tbl.push_back('{8'd200, 8'd7,   1'b0, 0, 8'd28,  8'd4,  1'b0});
      tbl.push_back('{8'd5,   8'd0,   1'b0, 0, 8'hFF,  8'd5,  1'b1});
      tbl.push_back('{8'd100, 8'd9,   1'b0, 5, 8'd11,  8'd1,  1'b0});
      tbl.push_back('{8'd255, 8'd255, 1'b0, 0, 8'd1,   8'd0,  1'b0});
      tbl.push_back('{8'd128, 8'd3,   1'b0, 1, 8'd42,  8'd2,  1'b0});
      tbl.push_back('{8'd1,   8'd255, 1'b0, 0, 8'd0,   8'd1,  1'b0});
`ifdef LONGDIV_SIGNED_EN
      tbl.push_back('{8'hF9,  8'h02,  1'b1, 0, 8'hFD,  8'hFF, 1'b0});
      tbl.push_back('{8'h80,  8'hFF,  1'b1, 0, 8'h80,  8'h00, 1'b0});
      tbl.push_back('{8'h07,  8'hFE,  1'b1, 0, 8'hFD,  8'h01, 1'b0});
      tbl.push_back('{8'hF9,  8'h00,  1'b1, 0, 8'hFF,  8'hF9, 1'b1});
`else
      tbl.push_back('{8'hF9,  8'h02,  1'b1, 0, 8'h7C,  8'h01, 1'b0});
      tbl.push_back('{8'h80,  8'hFF,  1'b1, 0, 8'h00,  8'h80, 1'b0});
      tbl.push_back('{8'h07,  8'hFE,  1'b1, 0, 8'h00,  8'h07, 1'b0});
      tbl.push_back('{8'hF9,  8'h00,  1'b1, 0, 8'hFF,  8'hF9, 1'b1});
`endif

      // Reset state is visible without any clock edge.
      #2;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_q", 32'(quotient), 32'd0);
      chk("rst_r", 32'(remainder), 32'd0);
      chk("rst_dbz", 32'(div_by_zero), 32'd0);
      repeat (2) @(negedge Clock);
      Resetn = 1'b1;

      foreach (tbl[i])
         run_op(tbl[i].a, tbl[i].b, tbl[i].sg, tbl[i].hold, tbl[i].q, tbl[i].r, tbl[i].z, 1'b0,
                $sformatf("tbl%0d", i));

      // Reset in the middle of CALC: no result, then a clean operation.
      @(negedge Clock);
      dividend = 8'd200;
      divisor  = 8'd7;
      in_valid = 1'b1;
      @(posedge Clock);
      #1;
      in_valid = 1'b0;
      repeat (3) @(posedge Clock);
      #1;
      Resetn = 1'b0;
      #1;
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_in_ready", 32'(in_ready), 32'd1);
      chk("midrst_q", 32'(quotient), 32'd0);
      chk("midrst_r", 32'(remainder), 32'd0);
      repeat (2) @(negedge Clock);
      Resetn = 1'b1;
      seen = 1'b0;
      repeat (12) begin
         @(posedge Clock);
         #1;
         if (out_valid) seen = 1'b1;
      end
      chk("midrst_no_output", 32'(seen), 32'd0);
      run_op(8'd255, 8'd1, 1'b0, 0, 8'd255, 8'd0, 1'b0, 1'b0, "after_rst");

      // Back-to-back: second accept on the edge right after the handshake edge.
      run_op(8'd255, 8'd1, 1'b0, 0, 8'd255, 8'd0, 1'b0, 1'b0, "b2b_first");
      prev_hs = hs_cyc;
      run_op(8'd0, 8'd255, 1'b0, 0, 8'd0, 8'd0, 1'b0, 1'b0, "b2b_second");
      chk("b2b_gap", 32'(acc_cyc - prev_hs), 32'd1);

      // Randomized operations against the reference model.
      for (int k = 0; k < 60; k++) begin
         ra = 8'($urandom);
         rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
         rs = 1'($urandom);
         exp = ref_div(ra, rb, rs);
         run_op(ra, rb, rs, int'($urandom_range(0, 2)), exp[16:9], exp[8:1], exp[0],
                bit'($urandom_range(0, 1)), $sformatf("rnd%0d", k));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
